pipe_add_sub: RTL and testbench
===============================

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 16, operand/result width in bits.
REQ-002 The module SHALL take parameter SEG_WIDTH, default 4, bits added per pipeline stage; NSTAGE = DATA_WIDTH/SEG_WIDTH.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair and op present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 A  input  DATA_WIDTH  signed two's-complement operand.
REQ-009 B  input  DATA_WIDTH  signed two's-complement operand.
REQ-010 op  input  1  0 = A+B, 1 = A-B.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 result  output  DATA_WIDTH  sum/difference.
REQ-014 overflow  output  1  signed overflow of the reported operation.

Function
REQ-015 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-016 Pipeline SHALL advance when adv = !out_valid | out_ready; in_ready SHALL equal adv.
REQ-017 When adv is low, all stage registers SHALL hold; no data lost or duplicated.
REQ-018 Subtraction SHALL be computed as A + ~B with carry-in 1; addition with carry-in 0.
REQ-019 Stage k (0..NSTAGE-1) SHALL add segment k (bits k*SEG_WIDTH..+SEG_WIDTH-1) with the registered carry from stage k-1, using per-bit propagate P=a^b, generate G=a&b, Cout=G|(P&C).
REQ-020 Higher operand segments SHALL be delayed (skewed) so each reaches its stage together with its carry; lower result segments SHALL be delayed to align at the output.
REQ-021 Latency SHALL be exactly NSTAGE cycles from accepted input to out_valid with no stall; throughput one op per cycle.
REQ-022 overflow SHALL be (~r&a&b)|(r&~a&~b) on the MSBs, where b is the effective (post-inversion) operand and r the raw sum MSB.
REQ-023 Each stage SHALL carry a valid bit; a stage with valid low SHALL not produce out_valid, bubbles flow through when adv is high.
REQ-024 Results SHALL emerge in acceptance order.
REQ-025 in_valid low with adv high SHALL insert a bubble; out_ready low with out_valid low SHALL not stall.
REQ-026 DATA_WIDTH not a multiple of SEG_WIDTH SHALL be an elaboration error; SEG_WIDTH=DATA_WIDTH SHALL give a single-stage, latency-1 unit.

Reset
REQ-027 On rst all stage valid bits SHALL clear; out_valid SHALL be 0 the cycle after rst is sampled.
REQ-028 During rst in_ready SHALL be 1; result and overflow SHALL be 0 after reset.
REQ-029 Reset mid-stream SHALL discard all in-flight operations; none SHALL appear afterward.

Configuration
REQ-030 Macro PIPE_ADD_SUB_SAT_EN defined: on overflow result SHALL clamp to max positive (2^(DATA_WIDTH-1)-1) if both effective operands are non-negative, else min negative (-2^(DATA_WIDTH-1)); overflow SHALL still assert.
REQ-031 Macro undefined: result SHALL be the wrapped modulo-2^DATA_WIDTH value; no clamp logic present.

Structure
REQ-032 Package pipe_add_sub_pkg SHALL hold the op encoding constants (OP_ADD=0, OP_SUB=1).
REQ-033 Per-stage segment adder SHALL be sub-module add_seg (SEG_WIDTH-bit, carry in/out, purely combinational); all registers live in pipe_add_sub.

Verification (DATA_WIDTH=16, SEG_WIDTH=4, latency 4)
REQ-034 add 0x1234+0x0101, out_ready=1 -> result 0x1335, overflow 0, out_valid exactly 4 cycles after accept.
REQ-035 add 0x0FFF+0x0001 -> 0x1000, overflow 0 (carry ripples through all stages).
REQ-036 add 0x7FFF+0x0001 -> overflow 1, result 0x8000 (wrap) / 0x7FFF (SAT_EN); sub 0x8000-0x0001 -> overflow 1, 0x7FFF (wrap) / 0x8000 (SAT_EN).
REQ-037 8 back-to-back ops, out_ready low 3 cycles mid-stream -> in_ready low those cycles, all 8 results correct, in order, none repeated.
REQ-038 rst asserted 2 cycles after 3 ops accepted -> out_valid 0 next cycle, no stale results after release; new op 0x0002-0x0003 -> 0xFFFF, overflow 0.

Source files
------------

// File: rtl/pipe_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// pipe_add_sub_pkg
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encoding of the 'op' input (0 = A+B, 1 = A-B).
// -----------------------------------------------------------------------------
package pipe_add_sub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_seg.sv
// -----------------------------------------------------------------------------
// add_seg
// Purely combinational WIDTH-bit ripple segment adder built from per-bit
// propagate/generate terms. One instance serves one pipeline stage.
// Ports:
//   i_a, i_b  : segment operands (i_b already inverted for subtraction)
//   i_cin     : carry into the segment
//   o_sum     : segment sum
//   o_cout    : carry out of the segment
// -----------------------------------------------------------------------------
module add_seg #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign w_p[gi]    = i_a[gi] ^ i_b[gi];
    assign w_g[gi]    = i_a[gi] & i_b[gi];
    assign w_c[gi+1]  = w_g[gi] | (w_p[gi] & w_c[gi]);
    assign o_sum[gi]  = w_p[gi] ^ w_c[gi];
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/pipe_add_sub.sv
// -----------------------------------------------------------------------------
// pipe_add_sub
// Carry-segmented pipelined signed adder/subtractor with valid/ready flow
// control. Each of the NSTAGE = DATA_WIDTH/SEG_WIDTH stages adds one
// SEG_WIDTH-bit segment using the carry registered by the previous stage.
// Operands travel with the pipeline so that each segment meets its carry;
// finished low result segments travel along so the full word aligns at the
// output. Latency is NSTAGE cycles, throughput one operation per cycle.
//
// Optional feature: define PIPE_ADD_SUB_SAT_EN to saturate the result on
// signed overflow instead of wrapping.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (A, B, op)
//   A, B                 : signed two's-complement operands
//   op                   : 0 = A+B, 1 = A-B
//   out_valid / out_ready: output handshake (result, overflow)
//   result               : sum or difference
//   overflow             : signed overflow of the reported operation
// -----------------------------------------------------------------------------
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow
);

  localparam int NSTAGE = DATA_WIDTH / SEG_WIDTH;

  if ((DATA_WIDTH % SEG_WIDTH) != 0) begin : g_bad_seg_width
    $error("pipe_add_sub: DATA_WIDTH must be a multiple of SEG_WIDTH");
  end

  // Registered outputs of every stage, exposed so stage k can read stage k-1.
  logic                  w_v_q [NSTAGE];
  logic                  w_c_q [NSTAGE];
  logic [DATA_WIDTH-1:0] w_a_q [NSTAGE];
  logic [DATA_WIDTH-1:0] w_b_q [NSTAGE];
  logic [DATA_WIDTH-1:0] w_s_q [NSTAGE];

  logic w_adv;

  assign out_valid = w_v_q[NSTAGE-1];
  assign w_adv     = !out_valid || out_ready;
  // While reset is held nothing is in flight, so inputs are never refused.
  assign in_ready  = w_adv || rst;

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
    localparam logic [DATA_WIDTH-1:0] SEG_MASK =
      ((DATA_WIDTH'(1) << SEG_WIDTH) - DATA_WIDTH'(1)) << (gi * SEG_WIDTH);

    logic                  w_v_in;
    logic                  w_c_in;
    logic [DATA_WIDTH-1:0] w_a_in;
    logic [DATA_WIDTH-1:0] w_b_in;
    logic [DATA_WIDTH-1:0] w_s_in;
    logic [DATA_WIDTH-1:0] w_s_next;
    logic [SEG_WIDTH-1:0]  w_seg_sum;
    logic                  w_seg_cout;

    logic                  r_v;
    logic                  r_c;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_s;

    if (gi == 0) begin : g_head
      // Subtraction is A + ~B + 1: invert once here, carry-in 1 to stage 0.
      assign w_v_in = in_valid;
      assign w_c_in = (op == OP_SUB);
      assign w_a_in = A;
      assign w_b_in = (op == OP_SUB) ? ~B : B;
      assign w_s_in = '0;
    end else begin : g_body
      assign w_v_in = w_v_q[gi-1];
      assign w_c_in = w_c_q[gi-1];
      assign w_a_in = w_a_q[gi-1];
      assign w_b_in = w_b_q[gi-1];
      assign w_s_in = w_s_q[gi-1];
    end

    add_seg #(
      .WIDTH(SEG_WIDTH)
    ) u_add_seg (
      .i_a   (w_a_in[gi*SEG_WIDTH +: SEG_WIDTH]),
      .i_b   (w_b_in[gi*SEG_WIDTH +: SEG_WIDTH]),
      .i_cin (w_c_in),
      .o_sum (w_seg_sum),
      .o_cout(w_seg_cout)
    );

    // Drop this stage's segment into the partially assembled sum word.
    assign w_s_next = (w_s_in & ~SEG_MASK) |
                      (DATA_WIDTH'(w_seg_sum) << (gi * SEG_WIDTH));

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v_in;
        r_c <= w_seg_cout;
        r_a <= w_a_in;
        r_b <= w_b_in;
        r_s <= w_s_next;
      end
    end

    assign w_v_q[gi] = r_v;
    assign w_c_q[gi] = r_c;
    assign w_a_q[gi] = r_a;
    assign w_b_q[gi] = r_b;
    assign w_s_q[gi] = r_s;
  end

  // Final carry and the low operand bits of the last stage have no consumer.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_c_q[NSTAGE-1],
                           w_a_q[NSTAGE-1][DATA_WIDTH-2:0],
                           w_b_q[NSTAGE-1][DATA_WIDTH-2:0]};

  logic [DATA_WIDTH-1:0] w_raw;
  logic                  w_a_msb;
  logic                  w_b_msb;
  logic                  w_r_msb;
  logic                  w_ovf;

  assign w_raw   = w_s_q[NSTAGE-1];
  assign w_a_msb = w_a_q[NSTAGE-1][DATA_WIDTH-1];
  assign w_b_msb = w_b_q[NSTAGE-1][DATA_WIDTH-1];
  assign w_r_msb = w_raw[DATA_WIDTH-1];
  // b is the effective (post-inversion) operand, so one rule covers add and sub.
  assign w_ovf   = (~w_r_msb & w_a_msb & w_b_msb) | (w_r_msb & ~w_a_msb & ~w_b_msb);

  assign overflow = w_ovf;

`ifdef PIPE_ADD_SUB_SAT_EN
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // Overflow implies equal operand signs, so the A sign picks the rail.
  assign result = !w_ovf ? w_raw : (w_a_msb ? MIN_NEG : MAX_POS);
`else
  assign result = w_raw;
`endif

endmodule

// File: tb/tb_pipe_add_sub.sv
module tb_pipe_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        overflow;

  always #5 clk = ~clk;

  pipe_add_sub #(
    .DATA_WIDTH(16),
    .SEG_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_res_q[$];
  logic        exp_ovf_q[$];

  // Reference: plain signed integer arithmetic, range-checked against 16 bits.
  function automatic void ref_calc(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, output logic [15:0] res,
                                   output logic ovf);
    int sa, sb, r;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = sub ? (sa - sb) : (sa + sb);
    ovf = (r > 32767) || (r < -32768);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (ovf) res = (r > 0) ? 16'h7FFF : 16'h8000;
    else     res = r[15:0];
`else
    res = r[15:0];
`endif
  endfunction

  task automatic pop_expect(output logic [15:0] er, output logic eo, output bit empty);
    empty = (exp_res_q.size() == 0);
    if (empty) begin
      er = 'x;
      eo = 1'bx;
    end else begin
      er = exp_res_q.pop_front();
      eo = exp_ovf_q.pop_front();
    end
  endtask

  // Advance one clock; record accepted inputs into the model and report
  // whether an output transfer happened on this edge.
  task automatic step(output bit got, output logic [15:0] res, output logic ovf);
    logic [15:0] er;
    logic        eo;
    got = out_valid && out_ready && !rst;
    res = result;
    ovf = overflow;
    if (in_valid && in_ready && !rst) begin
      ref_calc(A, B, op, er, eo);
      exp_res_q.push_back(er);
      exp_ovf_q.push_back(eo);
      $display("in : A=%h B=%h op=%0d", A, B, op);
    end
    if (got) $display("out: result=%h overflow=%b", res, ovf);
    @(posedge clk);
    #1;
  endtask

  // Send one operation into an empty pipe and take its result.
  task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic sub,
                            output int lat, output logic [15:0] res, output logic ovf);
    bit          got, empty;
    logic [15:0] r, er;
    logic        o, eo;
    int          guard;
    A = a; B = b; op = sub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step(got, r, o);
      guard++;
    end
    step(got, r, o);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      step(got, r, o);
      lat++;
    end
    res = result;
    ovf = overflow;
    step(got, r, o);
    pop_expect(er, eo, empty);
  endtask

  task automatic test_reset();
    bit          got;
    logic [15:0] r;
    logic        o;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step(got, r, o);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    step(got, r, o);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (result !== 16'h0000) begin
      n_bad++; $display("FAIL reset_result: got %h want 0000", result);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    exp_res_q.delete();
    exp_ovf_q.delete();
  endtask

  task automatic test_directed();
    logic [15:0] va [7] = '{16'h1234, 16'h0FFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
    logic [15:0] vb [7] = '{16'h0101, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h8000};
    logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] vw [7] = '{16'h1335, 16'h1000, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};
    logic [15:0] vt [7] = '{16'h1335, 16'h1000, 16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'h7FFF};
    logic        vo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int          lat;
    logic [15:0] res, want;
    logic        ovf;
    for (int i = 0; i < 7; i++) begin
      run_single(va[i], vb[i], vs[i], lat, res, ovf);
`ifdef PIPE_ADD_SUB_SAT_EN
      want = vt[i];
`else
      want = vw[i];
`endif
      n_cmp++;
      if (lat !== 4) begin
        n_bad++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat);
      end
      n_cmp++;
      if (res !== want) begin
        n_bad++; $display("FAIL directed%0d_result: got %h want %h", i, res, want);
      end
      n_cmp++;
      if (ovf !== vo[i]) begin
        n_bad++; $display("FAIL directed%0d_overflow: got %b want %b", i, ovf, vo[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit          got, empty, stall, accepted;
    logic [15:0] r, er;
    logic        o, eo;
    int          sent, recv, cyc, extra;
    sent = 0; recv = 0; cyc = 0;
    A = 16'($urandom); B = 16'($urandom); op = 1'($urandom);
    while ((sent < 8 || recv < 8) && cyc < 80) begin
      stall     = (cyc >= 5 && cyc <= 7);
      out_ready = !stall;
      in_valid  = (sent < 8);
      #1;
      if (stall) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++; $display("FAIL b2b_stall_in_ready cyc%0d: got %b want 0", cyc, in_ready);
        end
      end
      accepted = in_valid && in_ready;
      step(got, r, o);
      if (accepted) begin
        sent++;
        A = 16'($urandom); B = 16'($urandom); op = 1'($urandom);
      end
      if (got) begin
        recv++;
        pop_expect(er, eo, empty);
        n_cmp++;
        if (empty || r !== er || o !== eo) begin
          n_bad++;
          $display("FAIL b2b_result%0d: got %h/%b want %h/%b (empty=%0d)", recv, r, o, er, eo, empty);
        end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (recv !== 8 || exp_res_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_count: got %0d results want 8 (pending %0d)", recv, exp_res_q.size());
    end
    extra = 0;
    repeat (6) begin
      step(got, r, o);
      if (got) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++; $display("FAIL b2b_no_repeat: got %0d extra results want 0", extra);
    end
  endtask

  task automatic test_random();
    bit          got, empty;
    logic [15:0] r, er;
    logic        o, eo;
    int          guard;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      A = 16'($urandom); B = 16'($urandom); op = 1'($urandom);
      #1;
      step(got, r, o);
      if (got) begin
        pop_expect(er, eo, empty);
        n_cmp++;
        if (empty || r !== er || o !== eo) begin
          n_bad++; $display("FAIL random_result: got %h/%b want %h/%b (empty=%0d)", r, o, er, eo, empty);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while ((exp_res_q.size() != 0 || out_valid) && guard < 40) begin
      step(got, r, o);
      if (got) begin
        pop_expect(er, eo, empty);
        n_cmp++;
        if (empty || r !== er || o !== eo) begin
          n_bad++; $display("FAIL random_drain: got %h/%b want %h/%b (empty=%0d)", r, o, er, eo, empty);
        end
      end
      guard++;
    end
    n_cmp++;
    if (exp_res_q.size() != 0) begin
      n_bad++; $display("FAIL random_lost: got %0d results missing want 0", exp_res_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    bit          got, empty;
    logic [15:0] r, er, res;
    logic        o, eo, ovf;
    int          stale, lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = 16'($urandom); B = 16'($urandom); op = 1'($urandom);
      in_valid = 1'b1;
      #1;
      step(got, r, o);
    end
    in_valid = 1'b0;
    repeat (2) begin
      step(got, r, o);
      if (got) begin
        pop_expect(er, eo, empty);
        n_cmp++;
        if (empty || r !== er || o !== eo) begin
          n_bad++; $display("FAIL midrst_pre_result: got %h/%b want %h/%b", r, o, er, eo);
        end
      end
    end
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
    step(got, r, o);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid);
    end
    exp_res_q.delete();
    exp_ovf_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      if (out_valid) stale++;
      step(got, r, o);
    end
    n_cmp++;
    if (stale !== 0) begin
      n_bad++; $display("FAIL midrst_stale: got %0d stale cycles want 0", stale);
    end
    run_single(16'h0002, 16'h0003, 1'b1, lat, res, ovf);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL midrst_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if (res !== 16'hFFFF) begin
      n_bad++; $display("FAIL midrst_result: got %h want ffff", res);
    end
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_bad++; $display("FAIL midrst_overflow: got %b want 0", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
